sync_fifo_ctrl: RTL and testbench

- Pointer and flag controller for the dual-port synchronous FIFO.
- Sits directly upstream of the dual-port RAM (dp_ram) and drives it: RAM port 1 is the write port, RAM port 2 is the read-only port.
- Converts push/pop requests into RAM accesses, tracks occupancy, and returns read data with a valid strobe.
- Depth is 2**ADDR_WIDTH entries.

---
 rtl/sync_fifo_ctrl.sv | 92 +++++++++
 tb/tb_sync_fifo_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Pointer and flag controller for a dual-port synchronous FIFO.
// Drives dp_ram: port 1 writes, port 2 reads.
module sync_fifo_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic                  clr_err_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic                  ram_cs_o,
  output logic                  ram_wren1_o,
  output logic [ADDR_WIDTH-1:0] ram_addr1_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data1_o,
  output logic                  ram_wren2_o,
  output logic [ADDR_WIDTH-1:0] ram_addr2_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data2_i
);

  localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE    = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] count;
  logic                wr_acc;
  logic                rd_acc;

  // Extra MSB distinguishes full from empty when the low bits match.
  assign full_o  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign empty_o = (wr_ptr == rd_ptr);

  assign wr_acc = wr_en_i & ~full_o;
  assign rd_acc = rd_en_i & ~empty_o;

  assign almost_full_o  = (count >= AF_CNT);
  assign almost_empty_o = (count <= AE_CNT);
  assign count_o        = count;

  assign ram_cs_o       = wr_acc | rd_acc;
  assign ram_wren1_o    = wr_acc;
  assign ram_addr1_o    = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_data1_o = wr_data_i;
  assign ram_wren2_o    = 1'b0;
  assign ram_addr2_o    = rd_ptr[ADDR_WIDTH-1:0];
  assign rd_data_o      = ram_rd_data2_i;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Error flags are sticky; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_valid_o  <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      rd_valid_o  <= rd_acc;
      overflow_o  <= (overflow_o & ~clr_err_i) | (wr_en_i & full_o);
      underflow_o <= (underflow_o & ~clr_err_i) | (rd_en_i & empty_o);
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl with a behavioural RAM and a queue-based FIFO model.
module tb_sync_fifo_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int AE = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en, clr_err;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, afull, aempty, ovf_o, unf_o;
  logic [AW:0]   count;
  logic          ram_cs, ram_wren1, ram_wren2;
  logic [AW-1:0] ram_addr1, ram_addr2;
  logic [DW-1:0] ram_wdata1, ram_q;
  logic [DW-1:0] mem [DEPTH];

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf, m_unf, m_valid;
  logic [DW-1:0] m_data;
  int            wr_total, rd_total;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .rst_n_i(rst_n),
    .wr_en_i(wr_en),
    .wr_data_i(wr_data),
    .rd_en_i(rd_en),
    .clr_err_i(clr_err),
    .rd_data_o(rd_data),
    .rd_valid_o(rd_valid),
    .full_o(full),
    .empty_o(empty),
    .almost_full_o(afull),
    .almost_empty_o(aempty),
    .count_o(count),
    .overflow_o(ovf_o),
    .underflow_o(unf_o),
    .ram_cs_o(ram_cs),
    .ram_wren1_o(ram_wren1),
    .ram_addr1_o(ram_addr1),
    .ram_wr_data1_o(ram_wdata1),
    .ram_wren2_o(ram_wren2),
    .ram_addr2_o(ram_addr2),
    .ram_rd_data2_i(ram_q)
  );

  // Registered-read RAM behaving like dp_ram.
  always @(posedge clk) begin
    if (ram_cs && ram_wren1) mem[ram_addr1] <= ram_wdata1;
    if (ram_cs) ram_q <= mem[ram_addr2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("almost_full", 32'(afull), 32'(q.size() >= AF));
    chk("almost_empty", 32'(aempty), 32'(q.size() <= AE));
    chk("overflow", 32'(ovf_o), 32'(m_ovf));
    chk("underflow", 32'(unf_o), 32'(m_unf));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    if (m_valid) chk("rd_data", 32'(rd_data), 32'(m_data));
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_unf = 0; m_valid = 0;
    wr_total = 0; rd_total = 0;
  endtask

  // One clock cycle: drive at negedge, check RAM decode, advance model at posedge, check state.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re, input logic clr);
    bit full_m, empty_m, wacc, racc;
    wr_en = we; wr_data = wd; rd_en = re; clr_err = clr;
    #1;
    full_m  = (q.size() == DEPTH);
    empty_m = (q.size() == 0);
    wacc = we && !full_m;
    racc = re && !empty_m;
    chk("ram_cs", 32'(ram_cs), 32'(wacc | racc));
    chk("ram_wren1", 32'(ram_wren1), 32'(wacc));
    chk("ram_wren2", 32'(ram_wren2), 32'(0));
    chk("ram_addr1", 32'(ram_addr1), 32'(wr_total % DEPTH));
    chk("ram_addr2", 32'(ram_addr2), 32'(rd_total % DEPTH));
    if (wacc) chk("ram_wr_data1", 32'(ram_wdata1), 32'(wd));
    @(posedge clk);
    m_ovf = (m_ovf && !clr) || (we && full_m);
    m_unf = (m_unf && !clr) || (re && empty_m);
    m_valid = racc;
    if (racc) begin m_data = q.pop_front(); rd_total++; end
    if (wacc) begin q.push_back(wd); wr_total++; end
    #1;
    chk_state();
    @(negedge clk);
  endtask

  initial begin
    bit we, re;
    model_reset();
    rst_n = 1'b0; wr_en = 0; rd_en = 0; clr_err = 0; wr_data = '0;
    repeat (2) @(negedge clk);
    chk_state();
    chk("reset_ram_cs", 32'(ram_cs), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk_state();

    // Two-word round trip
    step(1, 8'hAB, 0, 0);
    step(1, 8'hCD, 0, 0);
    step(0, 8'h00, 1, 0);
    chk("first_pop_data", 32'(rd_data), 32'h AB);
    step(0, 8'h00, 1, 0);
    chk("second_pop_data", 32'(rd_data), 32'h CD);
    step(0, 8'h00, 0, 0);

    // Fill to full, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0);
    step(1, 8'hEE, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 8'h00, 1, 0);
      chk("drain_order", 32'(rd_data), 32'(i));
    end
    step(0, 8'h00, 0, 1);

    // Underflow and clear
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);
    // Clear and new error in the same cycle: set wins
    step(0, 8'h00, 1, 1);
    step(0, 8'h00, 0, 1);

    // Simultaneous push/pop at full and at half-full
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h40 + i), 0, 0);
    step(1, 8'h99, 1, 0);
    step(0, 8'h00, 0, 1);
    while (q.size() > 8) step(0, 8'h00, 1, 0);
    step(1, 8'h77, 1, 0);
    while (q.size() > 0) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Wrap-around with occupancy held at 3..5, reset mid-burst
    for (int i = 0; i < 4; i++) step(1, 8'(8'h80 + i), 0, 0);
    for (int i = 0; i < 40; i++) begin
      we = (q.size() < 5) && (($urandom % 2) == 1 || q.size() <= 3);
      re = (q.size() > 3) && (($urandom % 2) == 1 || q.size() >= 5);
      step(we, 8'(8'h84 + wr_total), re, 0);
    end
    wr_en = 0; rd_en = 0; clr_err = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 100) < 55, 8'($urandom), ($urandom % 100) < 45, ($urandom % 16) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
